pio_wmem_master: RTL and testbench
==================================

Name: pio_wmem_master

Overview:
- PIO initiator for wide (WIDTH > 32) PIO-mapped memories; drives the reg_* strobe bus that a wide-memory target decodes.
- Converts one wide read/write request on a valid/ready port into two 32-bit PIO accesses: LSB dword first, then MSB dword.
- Waits for the target's clk_div-stretched mem_ack on each access, assembles read data, and reports a timeout error if an ack never arrives.
- Sits between a test/host agent (CPU bridge, BIST, init engine) and the PIO bus.

Parameters:
- WIDTH, 40, wide word width; 33..64.
- DEPTH_NBITS, 10, wide-word index width.
- BASE_ADDR, 0, byte base address of the target memory in PIO space; 8-byte aligned.
- TIMEOUT, 255, maximum cycles to wait for the ack of one phase; 1..65535.

Ports:
- clk  in  1  clock.
- `RESET_SIG  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  master idle and accepting a request.
- req_wr  in  1  1 = write, 0 = read.
- req_idx  in  DEPTH_NBITS  wide-word index.
- req_wdata  in  WIDTH  write data.
- resp_valid  out  1  one-cycle pulse: request finished.
- resp_rdata  out  WIDTH  read data; valid with resp_valid on reads.
- resp_err  out  1  valid with resp_valid; 1 = timeout.
- reg_addr  out  `PIO_RANGE  byte address.
- reg_din  out  `PIO_RANGE  write dword.
- reg_rd  out  1  read strobe, one-cycle pulse.
- reg_wr  out  1  write strobe, one-cycle pulse.
- reg_ms  out  1  module select, high with each strobe.
- mem_ack  in  1  target ack; level, may stay high several cycles.
- mem_rdata  in  `PIO_RANGE  target read dword; valid while mem_ack is high.

Behaviour:
- Reset values: req_ready=0 during reset and 1 in the first IDLE cycle; resp_valid=0, resp_err=0, reg_rd=0, reg_wr=0, reg_ms=0, reg_addr=0, reg_din=0, resp_rdata=0.
- All outputs are registered.
- Addressing: LSB byte address = BASE_ADDR + req_idx*8; MSB byte address = LSB address + 4.
- LSB must always be accessed before MSB. The target latches the write LSB and captures the read MSB on the LSB access.
- ack_rise = mem_ack & ~mem_ack_d1, where mem_ack_d1 is a registered copy of mem_ack (reset 0).
- FSM states: IDLE, LSB_ISSUE, LSB_WAIT, MSB_GAP, MSB_ISSUE, MSB_WAIT, DONE.
  - IDLE: req_ready=1. On req_valid, capture req_wr, req_idx and req_wdata, then go to LSB_ISSUE.
  - LSB_ISSUE: one cycle. reg_ms=1; reg_rd or reg_wr=1; reg_addr=LSB; reg_din=wdata[31:0] (0 on reads). Load the timeout counter with TIMEOUT. Go to LSB_WAIT.
  - LSB_WAIT: strobes low; counter decrements each cycle.
    - On ack_rise, a read captures mem_rdata into rdata[31:0]; go to MSB_GAP.
    - On counter==0 with no ack, set err and go to DONE.
  - MSB_GAP: wait until mem_ack==0, so the stretched LSB ack is not taken as the MSB ack. The timeout counter is reloaded here and expiry goes to DONE with err. Go to MSB_ISSUE.
  - MSB_ISSUE: as LSB_ISSUE with reg_addr=MSB. reg_din = zero-extended wdata[WIDTH-1:32]; bits 31..WIDTH-32 are 0.
  - MSB_WAIT: on ack_rise, a read captures mem_rdata[WIDTH-33:0] into rdata[WIDTH-1:32]; go to DONE. Timeout is handled as in LSB_WAIT.
  - DONE: resp_valid=1 for one cycle with resp_rdata and resp_err; go to IDLE.
- resp_rdata holds its value until the next completion. On writes and on errors it reports the partially assembled data; the consumer ignores it.
- Latency: with the ack rising N cycles after a strobe in both phases, total latency from acceptance to resp_valid is 2N + gap + 4 cycles.
- Ack boundary conditions:
  - An ack in IDLE, or in an ISSUE state, is ignored.
  - An ack already high on entry to a WAIT state does not count; only a rising edge counts.
- A new req_valid is not accepted until DONE has passed; req_valid held high is accepted on the IDLE cycle after DONE.
- Reset mid-transaction returns to IDLE and drops strobes the next cycle; no response is generated.

Decomposition:
- Shared package/defines: state encodings, the PIO_DW_BYTES=4 and WMEM_STRIDE=8 constants, and the `PIO_RANGE/`PIO_NBITS macros from defines.vh.
- One natural sub-module: pio_ack_timer, holding the ack rise detector and the loadable down-counter with an expired flag.

Test Plan:
- Write idx=3, WIDTH=40, wdata=0xAB_1234_5678 against a responder model -> reg_wr at addr 0x18 with din=0x12345678, then at addr 0x1C with din=0x000000AB; resp_valid=1 with resp_err=0.
- Read idx=3 after that write -> reads at 0x18 then 0x1C; resp_rdata=0xAB_1234_5678.
- Responder holds mem_ack high for 4 cycles (clk_div/4) -> exactly two strobe pulses; the MSB strobe is issued only after mem_ack falls; read data is correct.
- No ack, TIMEOUT=8 -> resp_valid with resp_err=1 exactly 10 cycles after the LSB strobe; req_ready=1 on the next cycle.
- Back-to-back requests with req_valid held -> second LSB strobe occurs 2 cycles after the first resp_valid; no overlap of transactions.
- Reset asserted in MSB_WAIT -> no resp_valid, strobes 0, req_ready=1 one cycle after reset deasserts, mem_ack_d1 cleared.

Source files
------------

// File: rtl/pio_wmem_master_pkg.sv
// Shared constants, FSM encoding and PIO strobe-bus payload for the wide-memory PIO master.
package pio_wmem_master_pkg;

    localparam int unsigned PIO_NBITS    = 32;
    localparam int unsigned PIO_DW_BYTES = 4;
    localparam int unsigned WMEM_STRIDE  = 8;
    localparam int unsigned TMR_NBITS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LSB_ISSUE = 3'd1,
        ST_LSB_WAIT  = 3'd2,
        ST_MSB_GAP   = 3'd3,
        ST_MSB_ISSUE = 3'd4,
        ST_MSB_WAIT  = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    typedef struct packed {
        logic                 ms;
        logic                 rd;
        logic                 wr;
        logic [PIO_NBITS-1:0] addr;
        logic [PIO_NBITS-1:0] din;
    } pio_bus_t;

    // Byte address of the LSB (msb=0) or MSB (msb=1) dword of a wide word.
    function automatic logic [PIO_NBITS-1:0] dword_addr(
        input logic [PIO_NBITS-1:0] base,
        input logic [PIO_NBITS-1:0] idx,
        input logic                 msb
    );
        return base + (idx * PIO_NBITS'(WMEM_STRIDE)) + (msb ? PIO_NBITS'(PIO_DW_BYTES) : '0);
    endfunction

endpackage

// File: rtl/pio_ack_timer.sv
// Ack rising-edge detector plus loadable down-counter that flags a per-phase timeout.
module pio_ack_timer
    import pio_wmem_master_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ack,
    input  logic i_load,
    input  logic i_dec,
    output logic o_ack_rise_c,
    output logic o_expired_c
);

    logic                 r_ack_d1;
    logic [TMR_NBITS-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_d1 <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_ack_d1 <= i_ack;
            if (i_load) begin
                r_cnt <= TMR_NBITS'(LOAD_VAL);
            end else if (i_dec && (r_cnt != '0)) begin
                r_cnt <= r_cnt - TMR_NBITS'(1);
            end
        end
    end

    // A stretched ack only counts on its leading edge.
    assign o_ack_rise_c = i_ack & ~r_ack_d1;
    assign o_expired_c  = (r_cnt == '0);

endmodule

// File: rtl/pio_wmem_master.sv
// Splits one wide read/write request into an LSB then MSB 32-bit PIO access and
// waits for each stretched ack, assembling read data and flagging timeouts.
module pio_wmem_master
    import pio_wmem_master_pkg::*;
#(
    parameter int unsigned WIDTH       = 40,
    parameter int unsigned DEPTH_NBITS = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_wr,
    input  logic [DEPTH_NBITS-1:0] i_req_idx,
    input  logic [WIDTH-1:0]       i_req_wdata,
    output logic                   o_resp_valid,
    output logic [WIDTH-1:0]       o_resp_rdata,
    output logic                   o_resp_err,
    output logic [PIO_NBITS-1:0]   o_reg_addr,
    output logic [PIO_NBITS-1:0]   o_reg_din,
    output logic                   o_reg_rd,
    output logic                   o_reg_wr,
    output logic                   o_reg_ms,
    input  logic                   i_mem_ack,
    input  logic [PIO_NBITS-1:0]   i_mem_rdata
);

    localparam int unsigned HI_NBITS = WIDTH - PIO_NBITS;

    state_t                 r_state;
    logic                   r_req_ready;
    logic                   r_wr;
    logic [DEPTH_NBITS-1:0] r_idx;
    logic [HI_NBITS-1:0]    r_wdata_hi;
    logic [WIDTH-1:0]       r_rdata;
    logic [WIDTH-1:0]       r_resp_rdata;
    logic                   r_resp_valid;
    logic                   r_resp_err;
    pio_bus_t               r_pio;

    logic w_ack_rise;
    logic w_expired;
    logic w_tmr_load;
    logic w_tmr_dec;

    // Reload on each strobe and again when the LSB ack arrives, to bound the gap wait.
    assign w_tmr_load = (r_state == ST_LSB_ISSUE) || (r_state == ST_MSB_ISSUE) ||
                        ((r_state == ST_LSB_WAIT) && w_ack_rise);
    assign w_tmr_dec  = (r_state == ST_LSB_WAIT) || (r_state == ST_MSB_GAP) ||
                        (r_state == ST_MSB_WAIT);

    pio_ack_timer #(
        .LOAD_VAL (TIMEOUT)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ack        (i_mem_ack),
        .i_load       (w_tmr_load),
        .i_dec        (w_tmr_dec),
        .o_ack_rise_c (w_ack_rise),
        .o_expired_c  (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_wr         <= 1'b0;
            r_idx        <= '0;
            r_wdata_hi   <= '0;
            r_rdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_pio        <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_pio.ms     <= 1'b0;
            r_pio.rd     <= 1'b0;
            r_pio.wr     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_req_ready && i_req_valid) begin
                        r_req_ready <= 1'b0;
                        r_wr        <= i_req_wr;
                        r_idx       <= i_req_idx;
                        r_wdata_hi  <= i_req_wdata[WIDTH-1:PIO_NBITS];
                        r_pio.ms    <= 1'b1;
                        r_pio.rd    <= ~i_req_wr;
                        r_pio.wr    <= i_req_wr;
                        r_pio.addr  <= dword_addr(PIO_NBITS'(BASE_ADDR), PIO_NBITS'(i_req_idx), 1'b0);
                        r_pio.din   <= i_req_wr ? i_req_wdata[PIO_NBITS-1:0] : '0;
                        r_state     <= ST_LSB_ISSUE;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_LSB_ISSUE: r_state <= ST_LSB_WAIT;
                ST_LSB_WAIT: begin
                    if (w_ack_rise) begin
                        if (!r_wr) r_rdata[PIO_NBITS-1:0] <= i_mem_rdata;
                        r_state <= ST_MSB_GAP;
                    end else if (w_expired) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= r_rdata;
                        r_state      <= ST_DONE;
                    end
                end
                // The LSB ack may still be stretched; the MSB strobe waits for it to drop.
                ST_MSB_GAP: begin
                    if (!i_mem_ack) begin
                        r_pio.ms   <= 1'b1;
                        r_pio.rd   <= ~r_wr;
                        r_pio.wr   <= r_wr;
                        r_pio.addr <= dword_addr(PIO_NBITS'(BASE_ADDR), PIO_NBITS'(r_idx), 1'b1);
                        r_pio.din  <= r_wr ? PIO_NBITS'(r_wdata_hi) : '0;
                        r_state    <= ST_MSB_ISSUE;
                    end else if (w_expired) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= r_rdata;
                        r_state      <= ST_DONE;
                    end
                end
                ST_MSB_ISSUE: r_state <= ST_MSB_WAIT;
                ST_MSB_WAIT: begin
                    if (w_ack_rise) begin
                        if (!r_wr) begin
                            r_rdata[WIDTH-1:PIO_NBITS] <= i_mem_rdata[HI_NBITS-1:0];
                            r_resp_rdata <= {i_mem_rdata[HI_NBITS-1:0], r_rdata[PIO_NBITS-1:0]};
                        end else begin
                            r_resp_rdata <= r_rdata;
                        end
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_state      <= ST_DONE;
                    end else if (w_expired) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= r_rdata;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_reg_addr   = r_pio.addr;
    assign o_reg_din    = r_pio.din;
    assign o_reg_rd     = r_pio.rd;
    assign o_reg_wr     = r_pio.wr;
    assign o_reg_ms     = r_pio.ms;

endmodule

// File: tb/tb_pio_wmem_master.sv
// Directed bench for pio_wmem_master against a wide-memory target model with adjustable ack timing.
module tb_pio_wmem_master;

    localparam int unsigned WIDTH   = 40;
    localparam int unsigned DNB     = 10;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_wr;
    logic [DNB-1:0]    req_idx;
    logic [WIDTH-1:0]  req_wdata, resp_rdata;
    logic              resp_valid, resp_err;
    logic [31:0]       reg_addr, reg_din, mem_rdata;
    logic              reg_rd, reg_wr, reg_ms, mem_ack;

    always #5 clk = ~clk;

    pio_wmem_master #(
        .WIDTH(WIDTH), .DEPTH_NBITS(DNB), .BASE_ADDR(0), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
        .i_req_idx(req_idx), .i_req_wdata(req_wdata),
        .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
        .o_reg_addr(reg_addr), .o_reg_din(reg_din), .o_reg_rd(reg_rd), .o_reg_wr(reg_wr),
        .o_reg_ms(reg_ms), .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe log, sampled mid-cycle.
    typedef struct { int cyc; logic ms, rd, wr; logic [31:0] addr, din; } strobe_t;
    strobe_t slog[$];
    always @(negedge clk)
        if (reg_rd || reg_wr) slog.push_back('{cyc, reg_ms, reg_rd, reg_wr, reg_addr, reg_din});

    // Wide-memory target model: latches write LSB, captures read MSB on the LSB access.
    logic [63:0] tmem [0:1023];
    logic [31:0] wlatch, rlatch, rd_val, rsp_rdata;
    logic        rsp_ack, spur_ack;
    int          dly_cnt, hold_cnt;
    int          rsp_delay = 1, rsp_hold = 1;
    bit          rsp_en = 1'b1;

    assign mem_ack   = rsp_ack | spur_ack;
    assign mem_rdata = rsp_rdata;

    always @(posedge clk) begin
        if (rst) begin
            rsp_ack   <= 1'b0;
            rsp_rdata <= 32'hDEAD_BEEF;
            dly_cnt   <= 0;
            hold_cnt  <= 0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt <= hold_cnt - 1;
                if (hold_cnt == 1) begin rsp_ack <= 1'b0; rsp_rdata <= 32'hDEAD_BEEF; end
            end
            if (dly_cnt > 0) begin
                dly_cnt <= dly_cnt - 1;
                if (dly_cnt == 1) begin rsp_ack <= 1'b1; rsp_rdata <= rd_val; hold_cnt <= rsp_hold; end
            end
            if (rsp_en && reg_ms && (reg_rd || reg_wr)) begin
                if (reg_wr) begin
                    if (!reg_addr[2]) wlatch = reg_din;
                    else tmem[reg_addr[12:3]] = {reg_din, wlatch};
                end else if (!reg_addr[2]) begin
                    rd_val = tmem[reg_addr[12:3]][31:0];
                    rlatch = tmem[reg_addr[12:3]][63:32];
                end else begin
                    rd_val = rlatch;
                end
                dly_cnt <= rsp_delay;
            end
        end
    end

    task automatic send_req(input bit wr, input logic [DNB-1:0] idx, input logic [WIDTH-1:0] wd,
                            input bit keep, output bit ok, output int t_acc);
        req_valid = 1'b1; req_wr = wr; req_idx = idx; req_wdata = wd;
        ok = 1'b0; t_acc = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (req_ready) begin ok = 1'b1; t_acc = cyc; end
            @(negedge clk);
        end
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok, output int t, output logic [WIDTH-1:0] rd, output bit err);
        ok = 1'b0; t = -1; rd = '0; err = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (resp_valid) begin ok = 1'b1; t = cyc; rd = resp_rdata; err = resp_err; break; end
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit               wr;
        logic [DNB-1:0]   idx;
        logic [WIDTH-1:0] wdata;
        int               dly, hold;
        logic [WIDTH-1:0] exp_rdata;
        logic [31:0]      lsb_addr, msb_addr, lsb_din, msb_din;
    } vec_t;
    vec_t vecs [9];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               ok, er, bad;
        int               ta, tr, t1, nst;
        logic [WIDTH-1:0] rd;

        vecs[0] = '{1'b1, 10'd3,   40'hAB_1234_5678, 1, 1, 40'h0,            32'h18,   32'h1C,   32'h1234_5678, 32'h0000_00AB};
        vecs[1] = '{1'b0, 10'd3,   40'h0,            1, 1, 40'hAB_1234_5678, 32'h18,   32'h1C,   32'h0,         32'h0};
        vecs[2] = '{1'b1, 10'h3FF, 40'hFF_FFFF_FFFF, 2, 2, 40'h0,            32'h1FF8, 32'h1FFC, 32'hFFFF_FFFF, 32'h0000_00FF};
        vecs[3] = '{1'b0, 10'h3FF, 40'h0,            3, 4, 40'hFF_FFFF_FFFF, 32'h1FF8, 32'h1FFC, 32'h0,         32'h0};
        vecs[4] = '{1'b1, 10'd0,   40'h00_0000_0001, 1, 3, 40'h0,            32'h0,    32'h4,    32'h0000_0001, 32'h0};
        vecs[5] = '{1'b0, 10'd3,   40'h0,            2, 4, 40'hAB_1234_5678, 32'h18,   32'h1C,   32'h0,         32'h0};
        vecs[6] = '{1'b1, 10'd5,   40'h5A_A5A5_5A5A, 1, 1, 40'h0,            32'h28,   32'h2C,   32'hA5A5_5A5A, 32'h0000_005A};
        vecs[7] = '{1'b0, 10'd0,   40'h0,            1, 1, 40'h00_0000_0001, 32'h0,    32'h4,    32'h0,         32'h0};
        vecs[8] = '{1'b0, 10'd5,   40'h0,            2, 1, 40'h5A_A5A5_5A5A, 32'h28,   32'h2C,   32'h0,         32'h0};
        for (int i = 0; i < 1024; i++) tmem[i] = 64'h0;

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_idx = '0; req_wdata = '0; spur_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_flags", 64'({resp_valid, resp_err, reg_rd, reg_wr, reg_ms}), 64'd0);
        chk("rst_addr_din", {reg_addr, reg_din}, 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // Table of complete transactions; latency = 5 + 2*delay + hold in this target model.
        for (int k = 0; k < 9; k++) begin
            rsp_delay = vecs[k].dly; rsp_hold = vecs[k].hold; slog.delete();
            send_req(vecs[k].wr, vecs[k].idx, vecs[k].wdata, 1'b0, ok, ta);
            chk($sformatf("v%0d_accept", k), 64'(ok), 64'd1);
            wait_rsp(ok, tr, rd, er);
            chk($sformatf("v%0d_resp", k), 64'(ok), 64'd1);
            chk($sformatf("v%0d_err", k), 64'(er), 64'd0);
            if (!vecs[k].wr) chk($sformatf("v%0d_rdata", k), 64'(rd), 64'(vecs[k].exp_rdata));
            chk($sformatf("v%0d_latency", k), 64'(tr - ta), 64'(5 + 2 * vecs[k].dly + vecs[k].hold));
            chk($sformatf("v%0d_nstrobe", k), 64'(slog.size()), 64'd2);
            if (slog.size() == 2) begin
                chk($sformatf("v%0d_lsb_flags", k), 64'({slog[0].ms, slog[0].rd, slog[0].wr}), 64'({1'b1, !vecs[k].wr, vecs[k].wr}));
                chk($sformatf("v%0d_lsb_ad", k), {slog[0].addr, slog[0].din}, {vecs[k].lsb_addr, vecs[k].lsb_din});
                chk($sformatf("v%0d_msb_flags", k), 64'({slog[1].ms, slog[1].rd, slog[1].wr}), 64'({1'b1, !vecs[k].wr, vecs[k].wr}));
                chk($sformatf("v%0d_msb_ad", k), {slog[1].addr, slog[1].din}, {vecs[k].msb_addr, vecs[k].msb_din});
                chk($sformatf("v%0d_strobe_gap", k), 64'(slog[1].cyc - slog[0].cyc), 64'(2 + vecs[k].dly + vecs[k].hold));
            end
            @(negedge clk);
        end

        // No ack at all: error 10 cycles after the LSB strobe, ready right after.
        rsp_en = 1'b0; slog.delete();
        send_req(1'b0, 10'd2, '0, 1'b0, ok, ta);
        wait_rsp(ok, tr, rd, er);
        chk("tmo_resp", 64'(ok), 64'd1);
        chk("tmo_err", 64'(er), 64'd1);
        chk("tmo_nstrobe", 64'(slog.size()), 64'd1);
        if (slog.size() > 0) chk("tmo_delay", 64'(tr - slog[0].cyc), 64'd10);
        @(negedge clk);
        chk("tmo_ready_next", 64'(req_ready), 64'd1);

        // Ack already high when LSB_WAIT is entered must not count.
        slog.delete();
        send_req(1'b0, 10'd3, '0, 1'b0, ok, ta);
        spur_ack = 1'b1;
        wait_rsp(ok, tr, rd, er);
        chk("issue_ack_err", 64'(er), 64'd1);
        chk("issue_ack_nstrobe", 64'(slog.size()), 64'd1);
        if (slog.size() > 0) chk("issue_ack_delay", 64'(tr - slog[0].cyc), 64'd10);
        spur_ack = 1'b0; rsp_en = 1'b1;
        repeat (2) @(negedge clk);

        // Ack pulses while idle are ignored.
        slog.delete(); bad = 1'b0; spur_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) spur_ack = 1'b0;
            @(negedge clk);
            if (resp_valid || reg_rd || reg_wr || !req_ready) bad = 1'b1;
        end
        chk("idle_ack_ignored", 64'(bad), 64'd0);

        // Back-to-back with req_valid held: second LSB strobe 2 cycles after first resp_valid.
        rsp_delay = 1; rsp_hold = 2; slog.delete();
        send_req(1'b1, 10'd7, 40'h3C_0F0F_F0F0, 1'b1, ok, ta);
        req_wr = 1'b0;
        wait_rsp(ok, t1, rd, er);
        chk("b2b_first_resp", 64'(ok), 64'd1);
        chk("b2b_ready_in_done", 64'(req_ready), 64'd0);
        send_req(1'b0, 10'd7, '0, 1'b0, ok, ta);
        chk("b2b_accept_cycle", 64'(ta - t1), 64'd1);
        wait_rsp(ok, tr, rd, er);
        chk("b2b_rdata", 64'(rd), 64'h3C_0F0F_F0F0);
        chk("b2b_nstrobe", 64'(slog.size()), 64'd4);
        if (slog.size() == 4) begin
            chk("b2b_second_lsb", 64'(slog[2].cyc - t1), 64'd2);
            chk("b2b_no_overlap", 64'(slog[1].cyc < t1), 64'd1);
        end
        @(negedge clk);

        // Reset while waiting for the MSB ack.
        rsp_delay = 3; rsp_hold = 1;
        send_req(1'b0, 10'd3, '0, 1'b0, ok, ta);
        nst = 0;
        for (int i = 0; i < 40; i++) begin
            if (reg_rd) nst++;
            if (nst == 2) break;
            @(negedge clk);
        end
        chk("rstx_msb_strobe_seen", 64'(nst), 64'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstx_outs", 64'({resp_valid, reg_rd, reg_wr, reg_ms, req_ready}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstx_ready", 64'(req_ready), 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (resp_valid || reg_rd || reg_wr) bad = 1'b1;
            @(negedge clk);
        end
        chk("rstx_quiet", 64'(bad), 64'd0);

        // Recovery after reset.
        rsp_delay = 1; rsp_hold = 1;
        send_req(1'b0, 10'd3, '0, 1'b0, ok, ta);
        wait_rsp(ok, tr, rd, er);
        chk("post_rst_resp", 64'(ok), 64'd1);
        chk("post_rst_rdata", 64'(rd), 64'hAB_1234_5678);
        chk("post_rst_err", 64'(er), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
